instr_encoder: RTL and testbench
================================

# instr_encoder

Encodes field-level instruction requests (kind, registers, funct, immediate) into 32-bit RV32I instruction words and writes them sequentially into instruction memory through a buffered write port. It is the inverse of the core's opcode decoder: the boot/debug loader uses it to build test programs in imem without a host-side assembler. A DEPTH-entry FIFO decouples request acceptance from imem backpressure.

## Interface
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- ADDR_W, 32, imem byte-address width
- BASE_ADDR, 0, imem_addr value after reset
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept
- req_kind  in  4  0 LOAD, 1 STORE, 2 R, 3 B, 4 I, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 CSR; 10–15 illegal
- req_funct3  in  3  funct3 field
- req_funct7  in  7  funct7 field (R, and I shifts)
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  32  immediate, sign-extended value (byte offset for B/J)
- addr_load  in  1  load imem_addr from addr_val
- addr_val  in  ADDR_W  new write address
- imem_we  out  1  word valid at imem port
- imem_addr  out  ADDR_W  byte address of word
- imem_wdata  out  32  encoded instruction
- imem_ready  in  1  imem accepts word this cycle
- err_illegal  out  1  one-cycle pulse: illegal kind dropped
- enc_count  out  16  words written to imem since reset

## Operation
- Accept when req_valid && req_ready; req_ready = FIFO not full (no same-cycle pop bypass).
- Opcodes: LOAD 0000011, STORE 0100011, R 0110011, B 1100011, I 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, CSR 1110011.
- Formats: LOAD/I/JALR/CSR → I {imm[11:0], rs1, f3, rd, op}; STORE → S {imm[11:5], rs2, rs1, f3, imm[4:0], op}; R → {f7, rs2, rs1, f3, rd, op}; B → {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}; LUI/AUIPC → U {imm[31:12], rd, op}; JAL → J {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- I kind with f3 = 001 or 101: bits[31:25] = f7, bits[24:20] = imm[4:0].
- JALR: f3 forced 000. CSR: bits[31:20] = imm[11:0] (CSR address), f3 as given.
- Unused fields ignored; imm bits outside the format discarded, no range check.
- Illegal kind: accepted (consumes handshake), not pushed; err_illegal high the next cycle.
- FIFO head drives imem_wdata; imem_we = FIFO not empty. Pop on imem_we && imem_ready; then imem_addr += 4 (wraps mod 2^ADDR_W), enc_count += 1 (wraps at 2^16).
- addr_load: imem_addr = addr_val next cycle; overrides the +4 of a same-cycle pop (the popped word still uses the old address, enc_count still increments).

## Timing
- Reset: FIFO empty, imem_we 0, imem_wdata 0, imem_addr BASE_ADDR, req_ready 1, err_illegal 0, enc_count 0. rst mid-operation discards all buffered words.
- Latency: request accepted at edge N → imem_we high in cycle after N with its word (registered FIFO, fall-through head).
- Throughput: one accept and one pop per cycle; simultaneous push+pop leaves occupancy unchanged, legal even when full is not (full → req_ready 0).
- Empty: imem_we 0, imem_wdata holds last value (don't care). Full: req_ready 0 until a pop edge.
- imem_we/imem_addr/imem_wdata stable while imem_we && !imem_ready.
- err_illegal exactly one cycle per illegal accept; back-to-back illegal accepts → consecutive high cycles.

## Test plan
- Reset, send R kind add rd=3 rs1=1 rs2=2 f3=0 f7=0 → imem_wdata 0x002081B3 at addr 0x0 one cycle later, enc_count 1 after pop.
- Send I addi x1,x0,5 (imm 5), STORE sw x2,8(x1) (f3=010), B beq x1,x2,-8, JAL x1,+2048 → 0x00500093, 0x0020A423, 0xFE208CE3, 0x001000EF at addrs 0x0,0x4,0x8,0xC.
- Hold imem_ready 0, push DEPTH+1 requests → req_ready drops after DEPTH accepts; outputs stable; release → words drain in order, one per cycle.
- req_kind 12 → err_illegal pulse, no imem write, enc_count unchanged; next legal request proceeds normally.
- addr_load 0x100 coincident with a pop → popped word at old addr, next word at 0x100; imem_addr 0xFFFFFFFC pop → wraps to 0x0.
- Assert rst with 3 words buffered → imem_we 0, imem_addr BASE_ADDR, enc_count 0 the next cycle.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field-level requests into 32-bit words and
// streams them into instruction memory through a small FIFO.
module instr_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_val,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              err_illegal,
    output logic [15:0]       enc_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [31:0]      word;
    logic             accept, legal, push, pop;

    assign req_ready  = (count != (PTR_W+1)'(DEPTH));
    assign imem_we    = (count != '0);
    assign imem_wdata = mem[rd_ptr];
    assign accept     = req_valid && req_ready;
    assign legal      = (req_kind <= 4'd9);
    assign push       = accept && legal;
    assign pop        = imem_we && imem_ready;

    always_comb begin
        word = '0;
        case (req_kind)
            4'd0: word = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0000011};
            4'd1: word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0],
                          7'b0100011};
            4'd2: word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, 7'b0110011};
            4'd3: word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                          req_imm[4:1], req_imm[11], 7'b1100011};
            4'd4: begin
                // Shift-immediates carry funct7 in the upper imm bits.
                if (req_funct3 == 3'b001 || req_funct3 == 3'b101) begin
                    word = {req_funct7, req_imm[4:0], req_rs1, req_funct3, req_rd,
                            7'b0010011};
                end else begin
                    word = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0010011};
                end
            end
            4'd5: word = {req_imm[31:12], req_rd, 7'b0110111};
            4'd6: word = {req_imm[31:12], req_rd, 7'b0010111};
            4'd7: word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd,
                          7'b1101111};
            4'd8: word = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'b1100111};
            4'd9: word = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b1110011};
            default: word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            imem_addr   <= BASE_ADDR;
            err_illegal <= 1'b0;
            enc_count   <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                enc_count <= enc_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            // A load wins over the post-pop increment; the popped word used the old address.
            if (addr_load) begin
                imem_addr <= addr_val;
            end else if (pop) begin
                imem_addr <= imem_addr + ADDR_W'(4);
            end
            err_illegal <= accept && !legal;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: fixed vectors, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_instr_encoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_kind;
    logic [2:0]        req_funct3;
    logic [6:0]        req_funct7;
    logic [4:0]        req_rd, req_rs1, req_rs2;
    logic [31:0]       req_imm;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_val;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready;
    logic              err_illegal;
    logic [15:0]       enc_count;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR('0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .addr_load(addr_load), .addr_val(addr_val), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ready(imem_ready),
        .err_illegal(err_illegal), .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned fld(input int unsigned v, input int lo, input int n);
        return (v >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    // Reference encoder: place each field at its bit position arithmetically.
    function automatic logic [31:0] enc_model(input logic [3:0] k, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [31:0] imm);
        int unsigned opc [10] = '{3, 35, 51, 99, 19, 55, 23, 111, 103, 115};
        int unsigned i, op, w, f3v, rdv, r1, r2, f7v;
        i = imm; f3v = f3; rdv = rd; r1 = rs1; r2 = rs2; f7v = f7;
        if (k > 4'd9) return 32'h0;
        op = opc[k];
        case (k)
            4'd1: w = op | (fld(i, 0, 5) << 7) | (f3v << 12) | (r1 << 15) | (r2 << 20)
                      | (fld(i, 5, 7) << 25);
            4'd2: w = op | (rdv << 7) | (f3v << 12) | (r1 << 15) | (r2 << 20) | (f7v << 25);
            4'd3: w = op | (fld(i, 11, 1) << 7) | (fld(i, 1, 4) << 8) | (f3v << 12)
                      | (r1 << 15) | (r2 << 20) | (fld(i, 5, 6) << 25) | (fld(i, 12, 1) << 31);
            4'd5, 4'd6: w = op | (rdv << 7) | (i & 32'hFFFF_F000);
            4'd7: w = op | (rdv << 7) | (fld(i, 12, 8) << 12) | (fld(i, 11, 1) << 20)
                      | (fld(i, 1, 10) << 21) | (fld(i, 20, 1) << 31);
            default: begin
                if (k == 4'd8) f3v = 0;
                if (k == 4'd4 && (f3v == 1 || f3v == 5))
                    w = op | (rdv << 7) | (f3v << 12) | (r1 << 15) | (fld(i, 0, 5) << 20)
                        | (f7v << 25);
                else
                    w = op | (rdv << 7) | (f3v << 12) | (r1 << 15) | (fld(i, 0, 12) << 20);
            end
        endcase
        return w;
    endfunction

    // Cycle monitor: outputs sampled mid-cycle against the model, then the model
    // advances to what the next rising edge should produce.
    logic [31:0] exp_q [$];
    logic [31:0] m_addr = '0;
    logic [15:0] m_cnt = '0;
    logic        m_err = 1'b0;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin : mon
        bit mpop, macc;
        if (mon_en) begin
            check("mon_we", imem_we, exp_q.size() != 0);
            check("mon_ready", req_ready, exp_q.size() < DEPTH);
            check("mon_err", err_illegal, m_err);
            check("mon_count", enc_count, m_cnt);
            check("mon_addr", imem_addr, m_addr);
            if (exp_q.size() != 0) check("mon_wdata", imem_wdata, exp_q[0]);
            if (rst) begin
                exp_q.delete();
                m_addr = '0;
                m_cnt  = '0;
                m_err  = 1'b0;
            end else begin
                mpop  = (exp_q.size() != 0) && imem_ready;
                macc  = req_valid && (exp_q.size() < DEPTH);
                m_err = macc && (req_kind > 4'd9);
                if (mpop) begin
                    void'(exp_q.pop_front());
                    m_cnt = m_cnt + 16'd1;
                end
                if (addr_load) m_addr = addr_val;
                else if (mpop) m_addr = m_addr + 32'd4;
                if (macc && req_kind <= 4'd9)
                    exp_q.push_back(enc_model(req_kind, req_funct3, req_funct7, req_rd,
                                              req_rs1, req_rs2, req_imm));
            end
        end
    end

    typedef struct {
        bit          rst_first;
        logic [3:0]  kind;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic [31:0] addr;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [11];

    task automatic drive_fields(input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm);
        req_kind = k; req_funct3 = f3; req_funct7 = f7;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    endtask

    task automatic drive_random(input bit legal_only);
        drive_fields(legal_only ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 12)),
                     3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                     $urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bk_words [DEPTH+1];
        logic [31:0] w0, w1, hold_addr;
        logic [15:0] cnt0;
        int          n_acc;

        vecs[0]  = '{0, 4'd2, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3, 32'h00, 16'd1};
        vecs[1]  = '{1, 4'd4, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,        32'h00500093, 32'h00, 16'd1};
        vecs[2]  = '{0, 4'd1, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423, 32'h04, 16'd2};
        vecs[3]  = '{0, 4'd3, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 32'hFE208CE3, 32'h08, 16'd3};
        vecs[4]  = '{0, 4'd7, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h001000EF, 32'h0C, 16'd4};
        vecs[5]  = '{0, 4'd5, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 32'h10, 16'd5};
        vecs[6]  = '{0, 4'd8, 3'd7, 7'h00, 5'd1, 5'd5, 5'd0, 32'd0,        32'h000280E7, 32'h14, 16'd6};
        vecs[7]  = '{0, 4'd4, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd3,        32'h00309093, 32'h18, 16'd7};
        vecs[8]  = '{0, 4'd4, 3'd5, 7'h20, 5'd2, 5'd2, 5'd0, 32'd4,        32'h40415113, 32'h1C, 16'd8};
        vecs[9]  = '{0, 4'd9, 3'd2, 7'h00, 5'd3, 5'd0, 5'd0, 32'h300,      32'h300021F3, 32'h20, 16'd9};
        vecs[10] = '{0, 4'd0, 3'd2, 7'h00, 5'd4, 5'd2, 5'd0, 32'hFFFFFFFC, 32'hFFC12203, 32'h24, 16'd10};

        rst = 1'b1; req_valid = 1'b0; addr_load = 1'b0; addr_val = '0; imem_ready = 1'b1;
        drive_fields(4'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        step; step;
        rst = 1'b0;
        check("rst_we", imem_we, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_ready", req_ready, 1'b1);
        check("rst_err", err_illegal, 1'b0);
        check("rst_count", enc_count, 16'd0);
        mon_en = 1'b1;

        // Fixed vectors, one request at a time with imem always ready.
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].rst_first) begin
                rst = 1'b1; step; rst = 1'b0;
            end
            drive_fields(vecs[i].kind, vecs[i].f3, vecs[i].f7, vecs[i].rd, vecs[i].rs1,
                         vecs[i].rs2, vecs[i].imm);
            req_valid = 1'b1;
            step;
            req_valid = 1'b0;
            check("vec_we", imem_we, 1'b1);
            check("vec_wdata", imem_wdata, vecs[i].word);
            check("vec_addr", imem_addr, vecs[i].addr);
            step;
            check("vec_count", enc_count, vecs[i].cnt);
            check("vec_drained", imem_we, 1'b0);
        end

        // Backpressure: fill the FIFO, then one extra request waits.
        imem_ready = 1'b0;
        hold_addr = m_addr;
        n_acc = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive_random(1'b1);
            req_valid = 1'b1;
            bk_words[i] = enc_model(req_kind, req_funct3, req_funct7, req_rd, req_rs1,
                                    req_rs2, req_imm);
            if (req_ready) n_acc++;
            if (i < DEPTH) step;
        end
        check("bp_accepts", n_acc, DEPTH);
        check("bp_full", req_ready, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step;
            check("bp_hold_we", imem_we, 1'b1);
            check("bp_hold_data", imem_wdata, bk_words[0]);
            check("bp_hold_addr", imem_addr, hold_addr);
        end
        imem_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            check("bp_drain_we", imem_we, 1'b1);
            check("bp_drain_data", imem_wdata, bk_words[i]);
            check("bp_drain_addr", imem_addr, hold_addr + 32'(4 * i));
            if (req_valid && req_ready) begin
                step;
                req_valid = 1'b0;
            end else begin
                step;
            end
        end
        check("bp_empty", imem_we, 1'b0);

        // Illegal kinds: single pulse, then back-to-back pulses, then a legal request.
        cnt0 = m_cnt;
        drive_fields(4'd12, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd1);
        req_valid = 1'b1;
        step;
        req_valid = 1'b0;
        check("ill_err", err_illegal, 1'b1);
        check("ill_we", imem_we, 1'b0);
        check("ill_count", enc_count, cnt0);
        step;
        check("ill_err_clear", err_illegal, 1'b0);
        req_valid = 1'b1; req_kind = 4'd13;
        step;
        check("ill_b2b_0", err_illegal, 1'b1);
        req_kind = 4'd15;
        step;
        req_valid = 1'b0;
        check("ill_b2b_1", err_illegal, 1'b1);
        drive_fields(4'd2, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        req_valid = 1'b1;
        step;
        req_valid = 1'b0;
        check("ill_after_err", err_illegal, 1'b0);
        check("ill_after_data", imem_wdata, 32'h002081B3);
        step;
        check("ill_after_count", enc_count, cnt0 + 16'd1);

        // addr_load coincident with a pop.
        imem_ready = 1'b0;
        drive_random(1'b1);
        w0 = enc_model(req_kind, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm);
        req_valid = 1'b1;
        step;
        drive_random(1'b1);
        w1 = enc_model(req_kind, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm);
        step;
        req_valid = 1'b0;
        hold_addr = m_addr;
        cnt0 = m_cnt;
        check("ld_first_data", imem_wdata, w0);
        imem_ready = 1'b1; addr_load = 1'b1; addr_val = 32'h100;
        step;
        addr_load = 1'b0; imem_ready = 1'b0;
        check("ld_next_addr", imem_addr, 32'h100);
        check("ld_next_data", imem_wdata, w1);
        check("ld_count", enc_count, cnt0 + 16'd1);
        check("ld_old_addr_used", hold_addr != 32'h100, 1'b1);
        imem_ready = 1'b1;
        step;

        // Address wrap at the top of the space.
        addr_load = 1'b1; addr_val = 32'hFFFF_FFFC;
        step;
        addr_load = 1'b0;
        drive_random(1'b1);
        req_valid = 1'b1;
        step;
        req_valid = 1'b0;
        check("wrap_pre", imem_addr, 32'hFFFF_FFFC);
        step;
        check("wrap_post", imem_addr, 32'h0);

        // Reset with three words buffered.
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_random(1'b1);
            req_valid = 1'b1;
            step;
        end
        req_valid = 1'b0;
        check("rb_we_before", imem_we, 1'b1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        check("rb_we", imem_we, 1'b0);
        check("rb_addr", imem_addr, 32'h0);
        check("rb_count", enc_count, 16'd0);
        check("rb_ready", req_ready, 1'b1);

        // Randomized traffic; the monitor does the checking.
        for (int c = 0; c < 600; c++) begin
            drive_random(1'b0);
            req_valid  = ($urandom_range(0, 2) != 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            addr_load  = ($urandom_range(0, 31) == 0);
            addr_val   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
            rst        = ($urandom_range(0, 299) == 0);
            step;
        end
        rst = 1'b0; req_valid = 1'b0; addr_load = 1'b0; imem_ready = 1'b1;
        repeat (DEPTH + 2) step;
        check("final_empty", imem_we, 1'b0);
        @(negedge clk);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
